// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e  : fetch FSM states (FETCH, FAULT)
//   OPC_*        : RV32I control-transfer opcodes recognised by predecode
//   ifu_entry_t  : one buffered instruction {pc, instr, is_ctrl}
//   IFU_DEPTH    : instruction queue depth
//   IFU_RESET_PC : default first fetch address after reset
// ---------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } ifu_state_e;

  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [6:0]  OPC_JALR     = 7'b1100111;

  localparam int          IFU_DEPTH    = 2;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_ctrl;
  } ifu_entry_t;

  // True for branch, JAL and JALR encodings.
  function automatic logic is_ctrl_op(input logic [31:0] instr);
    return (instr[6:0] == OPC_BRANCH) ||
           (instr[6:0] == OPC_JAL)    ||
           (instr[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the instruction-memory port, the decode-side valid/ready stream
// and the redirect/fault signals of the fetch unit.
//   master : the fetch unit (drives o_* signals)
//   slave  : memory + decode + execute side (drives i_* signals)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_is_ctrl;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_fault;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_is_ctrl, o_fault,
    input  i_imem_rdata, i_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_is_ctrl, o_fault,
    output i_imem_rdata, i_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// IFU_DEPTH-entry instruction queue. Head entry is read combinationally so
// decode sees it the cycle it becomes valid.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push         : write i_push_entry at the tail
//   i_pop          : drop the head entry
//   i_flush        : empty the queue (overrides push/pop)
//   o_head         : head entry (stable while not popped)
//   o_count        : number of valid entries (0..IFU_DEPTH)
// ---------------------------------------------------------------------------
module ifu_fifo
  import ifu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  ifu_entry_t i_push_entry,
  input  logic       i_pop,
  input  logic       i_flush,
  output ifu_entry_t o_head,
  output logic [1:0] o_count
);

  ifu_entry_t             entry_reg [IFU_DEPTH];
  logic [1:0]             count_reg;
  logic                   wr_ptr_reg;
  logic                   rd_ptr_reg;
  logic                   do_push;
  logic                   do_pop;
  logic [IFU_DEPTH-1:0]   wr_en;

  assign do_pop  = i_pop && (count_reg != 2'd0);
  // A full queue may still accept a push when the head leaves this cycle.
  assign do_push = i_push && ((count_reg != 2'(IFU_DEPTH)) || do_pop);

  for (genvar gi = 0; gi < IFU_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && !i_flush && (wr_ptr_reg == 1'(gi));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < IFU_DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IFU_DEPTH; i++) begin
        if (wr_en[i]) begin
          entry_reg[i] <= i_push_entry;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign o_head  = entry_reg[rd_ptr_reg];
  assign o_count = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// RV32I instruction fetch unit: owns the fetch PC, issues word reads to a
// one-cycle-latency instruction memory, buffers returned words in a 2-entry
// queue and presents them to decode over valid/ready. A redirect flushes the
// queue, drops the in-flight response and restarts at the target; a
// misaligned target parks the unit in FAULT until an aligned redirect.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (master)   : imem req/addr/rdata, decode valid/ready/instr/pc/is_ctrl,
//                    redirect/redirect_pc, fault
// Parameter:
//   RESET_PC       : first fetch address after reset
// Build option:
//   IFU_PREDECODE_EN : when defined, each queued entry carries a flag marking
//                      branch/JAL/JALR opcodes; otherwise o_is_ctrl is 0.
// ---------------------------------------------------------------------------
module instr_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input logic           i_clk,
  input logic           i_rst_n,
  instr_fetch_if.master bus
);

  ifu_state_e  state_reg;
  ifu_state_e  state_next;
  logic [31:0] fetch_pc_reg;
  logic [31:0] inflight_pc_reg;
  logic        inflight_reg;
  logic        fetch_en;
  logic        fault;
  logic [1:0]  fifo_count;
  logic [1:0]  occupancy;
  ifu_entry_t  head;
  ifu_entry_t  push_entry;
  logic        push;
  logic        pop;
  logic        req;
  logic        redirect_aligned;
  logic        push_is_ctrl;

  assign redirect_aligned = (bus.i_redirect_pc[1:0] == 2'b00);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (bus.i_redirect) begin
      state_next = redirect_aligned ? FETCH : FAULT;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fetch_en = 1'b0;
    fault    = 1'b0;
    case (state_reg)
      FETCH: fetch_en = 1'b1;
      FAULT: fault    = 1'b1;
    endcase
  end

  // ---------------- Request / handshake ----------------
  // Occupancy counts queued words plus the one in flight, so a request is
  // only issued when its response is guaranteed a queue slot.
  assign occupancy = fifo_count + {1'b0, inflight_reg};
  assign pop       = bus.o_valid && bus.i_ready && !bus.i_redirect;
  assign req       = i_rst_n && fetch_en && !bus.i_redirect &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
  // A response arriving in a redirect cycle belongs to the old stream.
  assign push      = inflight_reg && !bus.i_redirect;

`ifdef IFU_PREDECODE_EN
  assign push_is_ctrl = is_ctrl_op(bus.i_imem_rdata);
`else
  assign push_is_ctrl = 1'b0;
`endif

  assign push_entry = '{pc: inflight_pc_reg, instr: bus.i_imem_rdata, is_ctrl: push_is_ctrl};

  // ---------------- PC and in-flight tracking ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
    end else if (bus.i_redirect) begin
      inflight_reg <= 1'b0;
      if (redirect_aligned) begin
        fetch_pc_reg <= bus.i_redirect_pc;
      end
    end else begin
      inflight_reg <= req;
      if (req) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;  // wraps modulo 2^32
      end
    end
  end

  ifu_fifo u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (push),
    .i_push_entry (push_entry),
    .i_pop        (pop),
    .i_flush      (bus.i_redirect),
    .o_head       (head),
    .o_count      (fifo_count)
  );

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc_reg;
  assign bus.o_valid     = (fifo_count != 2'd0);
  assign bus.o_instr     = head.instr;
  assign bus.o_pc        = head.pc;
  assign bus.o_is_ctrl   = head.is_ctrl;
  assign bus.o_fault     = fault;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed cycle table, a mid-operation reset sequence and a randomized run
// checked against a stream-level reference model of the fetch unit.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit rich_mode = 1'b0;

  // Memory contents. Plain mode: addr ^ A5A5_0000, with a JAL planted at 0x8.
  // Rich mode: scrambled words whose opcode cycles through a mix of classes.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit rich);
    logic [31:0] w;
    logic [6:0]  opc;
    if (!rich) begin
      return (a == 32'h8) ? 32'h0000_006F : (a ^ 32'hA5A5_0000);
    end
    w = (a ^ 32'hA5A5_0000) * 32'h9E37_79B1;
    case (a[4:2])
      3'd0:    opc = 7'h63;
      3'd1:    opc = 7'h6F;
      3'd2:    opc = 7'h67;
      3'd3:    opc = 7'h13;
      3'd4:    opc = 7'h33;
      3'd5:    opc = 7'h03;
      3'd6:    opc = 7'h23;
      default: opc = 7'h37;
    endcase
    return {w[31:7], opc};
  endfunction

  function automatic logic exp_ctrl(input logic [31:0] instr);
`ifdef IFU_PREDECODE_EN
    return (instr[6:0] == 7'b1100011) || (instr[6:0] == 7'b1101111) ||
           (instr[6:0] == 7'b1100111);
`else
    return 1'b0;
`endif
  endfunction

  // One-cycle-latency memory; garbage when not requested.
  always @(posedge clk) begin
    if (bus.o_imem_req) bus.i_imem_rdata <= mem_word(bus.o_imem_addr, rich_mode);
    else                bus.i_imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] ep;
    bit          er;
    logic [31:0] ea;
    bit          ef;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rdy, input bit rd, input logic [31:0] rpc,
                     input bit ev, input logic [31:0] ep,
                     input bit er, input logic [31:0] ea, input bit ef);
    vec_t v;
    v.ready = rdy; v.redir = rd; v.rpc = rpc;
    v.ev = ev; v.ep = ep; v.er = er; v.ea = ea; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, bus.o_imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.o_valid},    32'd0);
    check({tag, "_fault"}, {31'd0, bus.o_fault},    32'd0);
    check({tag, "_instr"}, bus.o_instr,             32'd0);
    check({tag, "_pc"},    bus.o_pc,                32'd0);
    check({tag, "_ctrl"},  {31'd0, bus.o_is_ctrl},  32'd0);
  endtask

  initial begin
    bit          pop;
    bit          m_fault;
    bit          req_last;
    logic [31:0] m_pc;
    logic [31:0] m_req;
    logic [31:0] rpc;
    int          outst;
    int          blank;
    int          queued;

    rst_n             = 1'b0;
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;

    // ---------------- Directed cycle table ----------------
    add(1,0,0, 0,32'h0,          1,32'h0,          0);  // C1 first request
    add(1,0,0, 0,32'h0,          1,32'h4,          0);
    add(1,0,0, 1,32'h0,          1,32'h8,          0);  // C3 first valid
    add(1,0,0, 1,32'h4,          1,32'hC,          0);
    add(1,0,0, 1,32'h8,          1,32'h10,         0);
    add(1,0,0, 1,32'hC,          1,32'h14,         0);
    for (int i = 0; i < 5; i++) add(0,0,0, 1,32'h10, 0,32'h0, 0);  // stall
    add(1,0,0, 1,32'h10,         1,32'h18,         0);
    add(1,0,0, 1,32'h14,         1,32'h1C,         0);
    add(1,0,0, 1,32'h18,         1,32'h20,         0);
    add(1,1,32'h100, 1,32'h1C,   0,32'h0,          0);  // redirect, void handshake
    add(1,0,0, 0,32'h0,          1,32'h100,        0);
    add(1,0,0, 0,32'h0,          1,32'h104,        0);
    add(1,0,0, 1,32'h100,        1,32'h108,        0);
    add(1,0,0, 1,32'h104,        1,32'h10C,        0);
    add(1,1,32'h102, 1,32'h108,  0,32'h0,          0);  // misaligned target
    for (int i = 0; i < 10; i++) add(1,0,0, 0,32'h0, 0,32'h0, 1);
    add(1,1,32'h200, 0,32'h0,    0,32'h0,          1);  // leave fault
    add(1,0,0, 0,32'h0,          1,32'h200,        0);
    add(1,0,0, 0,32'h0,          1,32'h204,        0);
    add(1,0,0, 1,32'h200,        1,32'h208,        0);
    add(1,1,32'hFFFF_FFF8, 1,32'h204, 0,32'h0,     0);
    add(1,0,0, 0,32'h0,          1,32'hFFFF_FFF8,  0);
    add(1,0,0, 0,32'h0,          1,32'hFFFF_FFFC,  0);
    add(1,0,0, 1,32'hFFFF_FFF8,  1,32'h0,          0);  // wrap
    add(1,0,0, 1,32'hFFFF_FFFC,  1,32'h4,          0);
    add(1,0,0, 1,32'h0,          1,32'h8,          0);
    add(1,0,0, 1,32'h4,          1,32'hC,          0);
    add(1,0,0, 1,32'h8,          1,32'h10,         0);  // JAL entry
    add(1,0,0, 1,32'hC,          1,32'h14,         0);

    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n             = 1'b1;
      bus.i_ready       = vecs[i].ready;
      bus.i_redirect    = vecs[i].redir;
      bus.i_redirect_pc = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, bus.o_valid},    {31'd0, vecs[i].ev});
      check($sformatf("v%0d_req", i),   {31'd0, bus.o_imem_req}, {31'd0, vecs[i].er});
      check($sformatf("v%0d_fault", i), {31'd0, bus.o_fault},    {31'd0, vecs[i].ef});
      if (vecs[i].ev) begin
        check($sformatf("v%0d_pc", i),    bus.o_pc,    vecs[i].ep);
        check($sformatf("v%0d_instr", i), bus.o_instr, mem_word(vecs[i].ep, 1'b0));
        check($sformatf("v%0d_ctrl", i),  {31'd0, bus.o_is_ctrl},
              {31'd0, exp_ctrl(mem_word(vecs[i].ep, 1'b0))});
      end
      if (vecs[i].er) check($sformatf("v%0d_addr", i), bus.o_imem_addr, vecs[i].ea);
      $display("vec %0d: valid=%0b pc=%h instr=%h ctrl=%0b req=%0b addr=%h fault=%0b",
               i, bus.o_valid, bus.o_pc, bus.o_instr, bus.o_is_ctrl,
               bus.o_imem_req, bus.o_imem_addr, bus.o_fault);
    end

    // ---------------- Randomized run vs stream model ----------------
    @(negedge clk);
    rst_n          = 1'b0;
    bus.i_redirect = 1'b0;
    rich_mode      = 1'b1;
    repeat (2) @(negedge clk);
    m_fault  = 1'b0;
    m_pc     = IFU_RESET_PC;
    m_req    = IFU_RESET_PC;
    outst    = 0;
    blank    = 2;
    req_last = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst_n          = 1'b1;
      bus.i_ready    = ($urandom_range(0, 3) != 0);
      bus.i_redirect = ($urandom_range(0, 39) == 0);
      rpc            = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 5) == 0) rpc[31:6] = '1;
      bus.i_redirect_pc = rpc;
      #1;
      pop = bus.o_valid && bus.i_ready && !bus.i_redirect;
      if (m_fault) begin
        check("rnd_fault_hold", {31'd0, bus.o_fault},    32'd1);
        check("rnd_fault_valid", {31'd0, bus.o_valid},   32'd0);
        check("rnd_fault_req",  {31'd0, bus.o_imem_req}, 32'd0);
      end else begin
        check("rnd_fault", {31'd0, bus.o_fault}, 32'd0);
        // Words requested two or more cycles ago and not yet taken are queued.
        queued = outst - (req_last ? 1 : 0);
        check("rnd_valid", {31'd0, bus.o_valid}, (queued > 0) ? 32'd1 : 32'd0);
        if (blank > 0) check("rnd_blank", {31'd0, bus.o_valid}, 32'd0);
        if (bus.i_redirect)
          check("rnd_req_redir", {31'd0, bus.o_imem_req}, 32'd0);
        else
          check("rnd_req", {31'd0, bus.o_imem_req},
                ((outst < 2) || (outst == 2 && pop)) ? 32'd1 : 32'd0);
        if (pop) begin
          check("rnd_pc",    bus.o_pc,    m_pc);
          check("rnd_instr", bus.o_instr, mem_word(m_pc, 1'b1));
          check("rnd_ctrl",  {31'd0, bus.o_is_ctrl}, {31'd0, exp_ctrl(mem_word(m_pc, 1'b1))});
          $display("rnd %0d: accept pc=%h instr=%h ctrl=%0b", cyc, bus.o_pc, bus.o_instr, bus.o_is_ctrl);
          m_pc  = m_pc + 32'd4;
          outst = outst - 1;
        end
        req_last = 1'b0;
        if (bus.o_imem_req) begin
          check("rnd_addr", bus.o_imem_addr, m_req);
          m_req    = m_req + 32'd4;
          outst    = outst + 1;
          req_last = 1'b1;
        end
        check("rnd_occupancy", (outst <= 2) ? 32'd1 : 32'd0, 32'd1);
      end
      if (blank > 0) blank--;
      if (bus.i_redirect) begin
        $display("rnd %0d: redirect to %h", cyc, rpc);
        outst    = 0;
        req_last = 1'b0;
        if (rpc[1:0] == 2'b00) begin
          m_fault = 1'b0;
          m_pc    = rpc;
          m_req   = rpc;
          blank   = 2;
        end else begin
          m_fault = 1'b1;
        end
      end
    end

    // ---------------- Reset asserted mid-operation ----------------
    @(negedge clk);
    rst_n          = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_ready    = 1'b0;
    #1;
    check("midrst_req_now", {31'd0, bus.o_imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check_reset_values("midrst");
    rich_mode = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    bus.i_ready = 1'b1;
    #1;
    check("midrst_c1_req",  {31'd0, bus.o_imem_req}, 32'd1);
    check("midrst_c1_addr", bus.o_imem_addr,         IFU_RESET_PC);
    @(negedge clk);
    #1;
    check("midrst_c2_valid", {31'd0, bus.o_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("midrst_valid", {31'd0, bus.o_valid}, 32'd1);
      check("midrst_pc",    bus.o_pc,    IFU_RESET_PC + 32'(4 * k));
      check("midrst_instr", bus.o_instr, mem_word(IFU_RESET_PC + 32'(4 * k), 1'b0));
      $display("midrst %0d: pc=%h instr=%h", k, bus.o_pc, bus.o_instr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that produces the 32-bit RV32I instruction stream consumed by the control/decode stage. It owns the program counter, issues word reads to a fixed-latency instruction memory, and buffers returned words in a 2-entry queue. Fetched words are presented to decode with a valid/ready handshake. A redirect from execute (taken branch, JAL/JALR) flushes the queue, discards in-flight data, and restarts fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  synchronous active-low reset
- o_imem_req  out  1  read request this cycle
- o_imem_addr  out  32  word address of request (bits [1:0] always 0)
- i_imem_rdata  in  32  read data, valid exactly 1 cycle after o_imem_req; memory never stalls
- o_valid  out  1  o_instr/o_pc hold a fetched instruction
- i_ready  in  1  decode accepts; transfer when o_valid && i_ready
- o_instr  out  32  instruction word
- o_pc  out  32  address of o_instr
- o_is_ctrl  out  1  predecoded branch/JAL/JALR flag (see Configuration)
- i_redirect  in  1  flush and restart fetch
- i_redirect_pc  in  32  restart address
- o_fault  out  1  fetch halted on misaligned redirect target

## Operation
- States: FETCH, FAULT. Reset state FETCH.
- Occupancy = queue count + in-flight (0/1). FETCH issues a request when occupancy < 2, or occupancy == 2 and a pop occurs this cycle; then fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0, no fault).
- In-flight response is pushed with its PC at the end of the cycle it returns.
- Queue is FIFO, depth 2; o_valid = count != 0; outputs driven from the head entry, stable while o_valid && !i_ready.
- Redirect (priority over everything): o_imem_req = 0 that cycle; queue cleared; in-flight flag cleared so the next-cycle response is dropped; a handshake in the same cycle is void. If i_redirect_pc[1:0] == 0: fetch_pc <= i_redirect_pc, stay/enter FETCH. Otherwise enter FAULT.
- FAULT: o_fault = 1, o_imem_req = 0, o_valid = 0; leave only by an aligned redirect (to FETCH) or reset.
- Reset values: o_imem_req 0, o_valid 0, o_fault 0, o_instr 0, o_pc 0, o_is_ctrl 0, queue empty, fetch_pc = RESET_PC.

## Timing
- Reset released at edge E0: request to RESET_PC during cycle 1, data cycle 2, o_valid cycle 3.
- Steady state with i_ready held 1: one instruction per cycle, no bubbles.
- i_ready low: at most 2 instructions buffered, requests stop; resume with no lost or duplicated words.
- Redirect in cycle N: o_valid 0 in N+1 and N+2; request to target in N+1; target instruction valid in N+3.
- Reset asserted mid-operation: returns to reset values on that edge; pending response discarded.

## Configuration
- IFU_PREDECODE_EN defined: each pushed entry carries o_is_ctrl = 1 when instr[6:0] is 7'b1100011, 7'b1101111 or 7'b1100111, else 0; computed at push, no added latency.
- Undefined: o_is_ctrl tied 0, no predecode storage.

## Structure
- Package ifu_pkg: state enum (FETCH, FAULT), opcode constants OPC_BRANCH/OPC_JAL/OPC_JALR, entry typedef {pc, instr, is_ctrl}, IFU_DEPTH = 2.
- One sub-module ifu_fifo: 2-entry queue with push, pop, flush, count; top holds PC, in-flight flag, FSM.

## Test plan
- Reset, i_ready = 1, memory returns addr ^ 32'hA5A5_0000: o_pc sequence 0, 4, 8, 12 on consecutive cycles from cycle 3, correct o_instr.
- i_ready = 0 for 5 cycles after first valid: o_imem_req stops after queue fills; on release o_pc continues 0, 4, 8 with no gaps or repeats.
- Redirect to 32'h0000_0100 in flight: old responses dropped, o_valid low 2 cycles, next o_pc = 0x100.
- Redirect to 32'h0000_0102: o_fault = 1, no requests for 10 cycles; redirect to 0x200 clears fault, o_pc = 0x200.
- Redirect to 32'hFFFF_FFF8: o_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, no fault.
- With IFU_PREDECODE_EN, memory returns 32'h0000_006F at 0x8: o_is_ctrl = 1 only for that entry; without macro always 0.
